// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// coin values and default hopper timing.
package change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EJ2   = 3'd1,
    ST_GAP2  = 3'd2,
    ST_EJ1   = 3'd3,
    ST_GAP1  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam int C1          = 1;
  localparam int C2          = 2;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_GAP     = 4;

endpackage

// File: rtl/change_dispenser_pend_ctr.sv
// Saturating pending-coin counter: adds up to 3 coins and removes one per edge
// as a net change; flags any coin clipped by saturation on the same cycle.
module pend_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         lost
);

  localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, cnt_q} + {{W{1'b0}}, inc};
    if (dec && (cnt_q != '0)) begin
      sum = sum - {{(W+1){1'b0}}, 1'b1};
    end
    cnt_d = sum[W-1:0];
    lost  = 1'b0;
    if (sum > MAX) begin
      cnt_d = MAX[W-1:0];
      lost  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// Coin-hopper driver: queues change requests and ejects coins one at a time
// (2-unit first) with ack handshake, release gap and timeout fault.
module change_dispenser
  import change_pkg::*;
#(
  parameter int PEND_W  = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP     = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              req2,
  input  logic              req22,
  input  logic              ack1,
  input  logic              ack2,
  output logic              eject1,
  output logic              eject2,
  output logic              busy,
  output logic              fault,
  output logic              overflow,
  output logic [PEND_W-1:0] pending1,
  output logic [PEND_W-1:0] pending2
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_N   = CW'(GAP);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          ej1_q, ej1_d;
  logic          ej2_q, ej2_d;
  logic          fault_q, fault_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    inc1, inc2;
  logic          dec1, dec2;
  logic          lost1, lost2;
  logic          is1, ack_sel;
  logic [CW-1:0] gap_nxt;

  assign inc1 = req1 ? 2'(C1) : 2'd0;
  assign inc2 = {1'b0, req2} + (req22 ? 2'd2 : 2'd0);

  pend_ctr #(.W(PEND_W)) u_pend1 (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc1),
    .dec  (dec1),
    .cnt  (pending1),
    .lost (lost1)
  );

  pend_ctr #(.W(PEND_W)) u_pend2 (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc2),
    .dec  (dec2),
    .cnt  (pending2),
    .lost (lost2)
  );

  assign is1     = (state_q == ST_EJ1) || (state_q == ST_GAP1);
  assign ack_sel = is1 ? ack1 : ack2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    ej1_d   = 1'b0;
    ej2_d   = 1'b0;
    fault_d = fault_q;
    ovf_d   = ovf_q | lost1 | lost2;
    dec1    = 1'b0;
    dec2    = 1'b0;
    gap_nxt = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pending2 != '0) begin
          state_d = ST_EJ2;
          ej2_d   = 1'b1;
        end else if (pending1 != '0) begin
          state_d = ST_EJ1;
          ej1_d   = 1'b1;
        end
      end
      ST_EJ1, ST_EJ2: begin
        if (ack_sel) begin
          dec1    = is1;
          dec2    = !is1;
          state_d = is1 ? ST_GAP1 : ST_GAP2;
          cnt_d   = '0;
          lvl_d   = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          ej1_d = is1;
          ej2_d = !is1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP1, ST_GAP2: begin
        // The shared counter measures the current run of equal ack levels.
        if (ack_sel) begin
          if (lvl_q && (cnt_q == TO_LAST)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            cnt_d = lvl_q ? cnt_q + CW'(1) : CW'(1);
            lvl_d = 1'b1;
          end
        end else begin
          gap_nxt = lvl_q ? CW'(1) : cnt_q + CW'(1);
          cnt_d   = gap_nxt;
          lvl_d   = 1'b0;
          if (gap_nxt == GAP_N) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      ej1_q   <= 1'b0;
      ej2_q   <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      ej1_q   <= ej1_d;
      ej2_q   <= ej2_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
    end
  end

  assign eject1   = ej1_q;
  assign eject2   = ej2_q;
  assign fault    = fault_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) || (pending1 != '0) || (pending2 != '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: request accounting table plus
// hand-written handshake, gap, timeout and reset sequences.
module tb_change_dispenser;

  localparam int PEND_W  = 4;
  localparam int TIMEOUT = 1000;
  localparam int GAP     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req1 = 1'b0, req2 = 1'b0, req22 = 1'b0;
  logic ack1 = 1'b0, ack2 = 1'b0;
  logic eject1, eject2, busy, fault, overflow;
  logic [PEND_W-1:0] pending1, pending2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  change_dispenser #(.PEND_W(PEND_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .req1     (req1),
    .req2     (req2),
    .req22    (req22),
    .ack1     (ack1),
    .ack2     (ack2),
    .eject1   (eject1),
    .eject2   (eject2),
    .busy     (busy),
    .fault    (fault),
    .overflow (overflow),
    .pending1 (pending1),
    .pending2 (pending2)
  );

  typedef struct {
    logic r1;
    logic r2;
    logic r22;
    int   p1;
    int   p2;
    int   ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // The two hoppers must never be commanded at once.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (eject1 && eject2) begin
        n_err++;
        $display("FAIL eject_overlap: eject1=%0b eject2=%0b, expected not both", eject1, eject2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r1, input logic r2, input logic r22);
    req1 = r1; req2 = r2; req22 = r22;
    tick();
    req1 = 1'b0; req2 = 1'b0; req22 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ack1 = 1'b0; ack2 = 1'b0;
    req1 = 1'b0; req2 = 1'b0; req22 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_eject(output int which, input int limit);
    which = 0;
    for (int i = 0; i < limit && which == 0; i++) begin
      if (eject2) which = 2;
      else if (eject1) which = 1;
      else tick();
    end
    if (which == 0) chk("eject_wait_timeout", 0, 1);
  endtask

  initial begin
    int w;
    int k;
    int stuck;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1, 0,  0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1, 1,  0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1, 3,  0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1, 6,  0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 2, 9,  0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2, 9,  0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 2, 12, 0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 2, 15, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2, 15, 1};

    // Reset state
    do_reset();
    chk("rst_eject1", int'(eject1), 0);
    chk("rst_eject2", int'(eject2), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pending1", int'(pending1), 0);
    chk("rst_pending2", int'(pending2), 0);

    // Single 2-unit coin, ack three cycles after eject
    pulse(1'b0, 1'b1, 1'b0);
    chk("t1_pending2_req", int'(pending2), 1);
    chk("t1_eject2_latency", int'(eject2), 0);
    tick();
    chk("t1_eject2_rise", int'(eject2), 1);
    tick();
    chk("t1_eject2_hold1", int'(eject2), 1);
    tick();
    chk("t1_eject2_hold2", int'(eject2), 1);
    ack2 = 1'b1;
    tick();
    chk("t1_eject2_fall", int'(eject2), 0);
    chk("t1_pending2_dec", int'(pending2), 0);
    ack2 = 1'b0;
    tick(); tick(); tick();
    chk("t1_busy_in_gap", int'(busy), 1);
    tick();
    chk("t1_busy_idle", int'(busy), 0);

    // req1 + req22 together: order 2,2,1
    do_reset();
    pulse(1'b1, 1'b0, 1'b1);
    chk("t2_pending1", int'(pending1), 1);
    chk("t2_pending2", int'(pending2), 2);
    for (int c = 0; c < 3; c++) begin
      wait_eject(w, 40);
      chk("t2_eject_order", w, (c < 2) ? 2 : 1);
      if (w == 1) ack1 = 1'b1;
      else if (w == 2) ack2 = 1'b1;
      tick();
      chk("t2_eject_drop", int'(eject1 | eject2), 0);
      ack1 = 1'b0; ack2 = 1'b0;
    end
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("t2_idle", int'(busy), 0);
    chk("t2_pending1_end", int'(pending1), 0);
    chk("t2_pending2_end", int'(pending2), 0);

    // Accounting table, no acks
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].r1, tbl[i].r2, tbl[i].r22);
      chk("tbl_pending1", int'(pending1), tbl[i].p1);
      chk("tbl_pending2", int'(pending2), tbl[i].p2);
      chk("tbl_overflow", int'(overflow), tbl[i].ovf);
    end

    // 16 req1 pulses saturate at 15
    do_reset();
    for (int i = 0; i < 15; i++) pulse(1'b1, 1'b0, 1'b0);
    chk("t3_pending1_15", int'(pending1), 15);
    chk("t3_overflow_clear", int'(overflow), 0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("t3_pending1_sat", int'(pending1), 15);
    chk("t3_overflow_set", int'(overflow), 1);

    // Eject timeout -> FAULT
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    wait_eject(w, 10);
    chk("t4_eject1", w, 1);
    k = 0;
    while (eject1 && k < 1100) begin tick(); k++; end
    chk("t4_eject_cycles", k, TIMEOUT);
    chk("t4_fault", int'(fault), 1);
    chk("t4_eject1_low", int'(eject1), 0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t4_pending2_in_fault", int'(pending2), 1);
    repeat (5) tick();
    chk("t4_no_eject2", int'(eject2), 0);
    chk("t4_fault_sticky", int'(fault), 1);
    chk("t4_busy", int'(busy), 1);

    // Reset mid-eject discards the queue
    do_reset();
    pulse(1'b0, 1'b1, 1'b1);
    chk("t6_pending2_3", int'(pending2), 3);
    wait_eject(w, 10);
    chk("t6_eject2", w, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_eject2_low", int'(eject2), 0);
    chk("t6_pending2_0", int'(pending2), 0);
    chk("t6_fault_0", int'(fault), 0);
    chk("t6_busy_0", int'(busy), 0);
    tick();
    chk("t6_eject2_stays_low", int'(eject2), 0);

    // ack2 stuck high after eject: gap release, then stuck-ack fault
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    wait_eject(w, 10);
    chk("t5_eject2", w, 2);
    ack2 = 1'b1;
    tick();
    chk("t5_eject2_drop", int'(eject2), 0);
    chk("t5_pending2_1", int'(pending2), 1);
    stuck = 0;
    repeat (20) begin
      tick();
      if (eject1 || eject2) stuck = 1;
    end
    chk("t5_no_eject_ack_high", stuck, 0);
    ack2 = 1'b0;
    k = 0;
    while (!eject2 && k < 50) begin tick(); k++; end
    chk("t5_gap_release", k, GAP + 1);
    ack2 = 1'b1;
    tick();
    chk("t5_eject2_drop2", int'(eject2), 0);
    chk("t5_pending2_0", int'(pending2), 0);
    k = 0;
    while (!fault && k < 1100) begin tick(); k++; end
    chk("t5_stuck_ack_cycles", k, TIMEOUT);
    chk("t5_fault", int'(fault), 1);
    chk("t5_ejects_low", int'(eject1 | eject2), 0);
    ack2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
